instr_mem_pipe: RTL

//  Parametrised instruction memory for the two-bit-predictor core fetch stage; replaces fixed test ROMs.

---
 rtl/imem_pkg.sv | 29 ++
 rtl/imem_pipe_stage.sv | 43 ++++
 rtl/instr_mem_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory fetch pipeline.
package imem_pkg;

  // Error cause reported with every fetch response.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_RSVD     = 2'd3
  } err_e;

  // addi x0,x0,0: returned whenever there is no real instruction to hand out.
  localparam logic [31:0] NOP_INSTR_DEF = 32'h00000013;

  // Classify a fetch address. Misalignment outranks the range check, so an
  // unaligned address past the end of memory still reports ERR_MISALIGN.
  function automatic err_e classify(input logic [31:0] addr, input logic [32:0] limit);
    err_e cause;
    if (addr[1:0] != 2'b00) begin
      cause = ERR_MISALIGN;
    end else if ({1'b0, addr} >= limit) begin
      cause = ERR_RANGE;
    end else begin
      cause = ERR_NONE;
    end
    return cause;
  endfunction

endpackage

// File: rtl/imem_pipe_stage.sv
// One delay stage of the fetch response pipeline: carries {valid, addr, instr, err}.
// A flush kills whatever is entering the stage; the payload only moves with a valid
// entry so the downstream address holds its last reported value.
module imem_pipe_stage
  import imem_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              src_valid,
  input  logic [31:0]       src_addr,
  input  logic [DATA_W-1:0] src_instr,
  input  err_e              src_err,
  output logic              valid,
  output logic [31:0]       addr,
  output logic [DATA_W-1:0] instr,
  output err_e              err
);

  logic take;
  assign take = src_valid & ~flush;

  // Advance the entry one stage, dropping it on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      instr <= NOP_INSTR;
      err   <= ERR_NONE;
    end else begin
      valid <= take;
      if (take) begin
        addr  <= src_addr;
        instr <= src_instr;
        err   <= src_err;
      end
    end
  end

endmodule

// File: rtl/instr_mem_pipe.sv
// Instruction memory for the fetch stage: byte-addressed request/response port with
// LATENCY cycles of delay, per-request error reporting, flush on redirect and a
// program-load write port. The array read is registered so the array maps to block RAM.
module instr_mem_pipe
  import imem_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 DEPTH     = 1024,
  parameter int                 LATENCY   = 1,
  parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(NOP_INSTR_DEF),
  parameter string              INIT_FILE = ""
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  input  logic [31:0]              req_addr_i,
  output logic                     req_ready_o,
  input  logic                     flush_i,
  output logic                     rsp_valid_o,
  output logic [31:0]              rsp_addr_o,
  output logic [DATA_W-1:0]        rsp_instr_o,
  output err_e                     rsp_err_o,
  input  logic                     ld_en_i,
  input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
  input  logic [DATA_W-1:0]        ld_data_i
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

  // Reject unsupported configurations at elaboration.
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $fatal(1, "instr_mem_pipe: LATENCY must be within 1..4");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "instr_mem_pipe: DEPTH must be a power of two");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // A load cycle owns the array, so fetch and write never collide.
  logic          accept;
  logic [AW-1:0] rd_idx;
  assign req_ready_o = ~ld_en_i;
  assign accept      = req_valid_i & req_ready_o;
  assign rd_idx      = req_addr_i[AW+1:2];

  // Program-load write port.
  always_ff @(posedge clk_i) begin
    if (ld_en_i) begin
      mem[ld_addr_i] <= ld_data_i;
    end
  end

  // Registered array read; no reset so it stays a plain block RAM output register.
  logic [DATA_W-1:0] rd_data;
  always_ff @(posedge clk_i) begin
    if (accept) begin
      rd_data <= mem[rd_idx];
    end
  end

  // Stage 1 control beside the RAM read. Flush does not touch this stage: the
  // request accepted on the flush edge is the redirect target and must survive.
  logic        s1_valid;
  logic [31:0] s1_addr;
  err_e        s1_err;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_err   <= ERR_NONE;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr <= req_addr_i;
        s1_err  <= classify(req_addr_i, ADDR_LIMIT);
      end
    end
  end

  // Stage chain; index 0 is the RAM stage, index LATENCY-1 drives the response.
  logic              st_valid [LATENCY];
  logic [31:0]       st_addr  [LATENCY];
  logic [DATA_W-1:0] st_instr [LATENCY];
  err_e              st_err   [LATENCY];

  assign st_valid[0] = s1_valid;
  assign st_addr[0]  = s1_addr;
  assign st_instr[0] = (s1_err == ERR_NONE) ? rd_data : NOP_INSTR;
  assign st_err[0]   = s1_err;

  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
    imem_pipe_stage #(
      .DATA_W    (DATA_W),
      .NOP_INSTR (NOP_INSTR)
    ) u_stage (
      .clk       (clk_i),
      .rst       (rst_i),
      .flush     (flush_i),
      .src_valid (st_valid[gi-1]),
      .src_addr  (st_addr[gi-1]),
      .src_instr (st_instr[gi-1]),
      .src_err   (st_err[gi-1]),
      .valid     (st_valid[gi]),
      .addr      (st_addr[gi]),
      .instr     (st_instr[gi]),
      .err       (st_err[gi])
    );
  end

  // With a single stage every in-flight fetch has already responded, so flush has no target.
  if (LATENCY == 1) begin : g_no_flush
    logic flush_unused;
    assign flush_unused = flush_i;
  end

  // Idle cycles show a NOP with no error; the address keeps the last response.
  assign rsp_valid_o = st_valid[LATENCY-1];
  assign rsp_addr_o  = st_addr[LATENCY-1];
  assign rsp_instr_o = st_valid[LATENCY-1] ? st_instr[LATENCY-1] : NOP_INSTR;
  assign rsp_err_o   = st_valid[LATENCY-1] ? st_err[LATENCY-1] : ERR_NONE;

endmodule
